// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: framer state encoding, error bit positions,
// CRC-16/MODBUS constants and the broadcast station address.
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RECV,
    ST_WAIT_EOF,
    ST_HOLD
  } rx_state_e;

  // frm_err = {uart, ovf, gap, crc, short}
  localparam int ERR_SHORT = 0;
  localparam int ERR_CRC   = 1;
  localparam int ERR_GAP   = 2;
  localparam int ERR_OVF   = 3;
  localparam int ERR_UART  = 4;
  localparam int ERR_W     = 5;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'hA001;

  localparam logic [7:0] MODBUS_BCAST_ADDR = 8'h00;

endpackage

// File: rtl/modbus_crc16_byte.sv
// Combinational CRC-16/MODBUS update: folds one byte into the running CRC,
// LSB first, eight unrolled shift/xor steps.
module modbus_crc16_byte
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: delimits frames by line silence, buffers the
// bytes, validates CRC and station address, and hands the frame to the decoder.
module modbus_rtu_rx_framer
  import modbus_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int TICK_W  = 20,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [TICK_W-1:0] cfg_t15,
  input  logic [TICK_W-1:0] cfg_t35,
  input  logic [7:0]        cfg_slave_addr,
  input  logic              cfg_addr_chk,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  output logic              frm_done,
  output logic [LEN_W-1:0]  frm_len,
  output logic              frm_ok,
  output logic [4:0]        frm_err,
  input  logic [LEN_W-2:0]  frm_rd_addr,
  output logic [7:0]        frm_rd_data,
  input  logic              frm_ack,
  output logic              busy
);

  localparam int AW = LEN_W - 1;

  rx_state_e         state, state_d;
  logic [TICK_W-1:0] sil;
  logic [LEN_W-1:0]  len, len_d;
  logic [15:0]       crc, crc_d, crc_nxt;
  logic [ERR_W-1:0]  flags, flags_d;
  logic [ERR_W-1:0]  close_err;
  logic [7:0]        addr0, addr0_d;
  logic              take, wr_en, done_d, addr_ok;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        mem [MAX_LEN];

  modbus_crc16_byte u_crc (
    .crc_in  (crc),
    .data    (rx_data),
    .crc_out (crc_nxt)
  );

  // Silence counter runs in every state; any received byte restarts it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)        sil <= '0;
    else if (rx_valid)   sil <= '0;
    else if (sil != '1)  sil <= sil + TICK_W'(1);
  end

  // Station address is latched from the first byte so the close decision
  // never needs a second RAM read port.
  assign addr_ok = !cfg_addr_chk || (addr0 == cfg_slave_addr) ||
                   (addr0 == MODBUS_BCAST_ADDR);

  always_comb begin
    close_err            = flags;
    close_err[ERR_SHORT] = (len < LEN_W'(4));
    close_err[ERR_CRC]   = (crc != 16'h0000);
  end

  always_comb begin
    state_d = state;
    len_d   = len;
    crc_d   = crc;
    flags_d = flags;
    addr0_d = addr0;
    take    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    done_d  = 1'b0;

    case (state)
      ST_INIT: begin
        if (!rx_valid && sil >= cfg_t35) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rx_valid) begin
          take    = 1'b1;
          addr0_d = rx_data;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid)              take    = 1'b1;
        else if (sil >= cfg_t15)   state_d = ST_WAIT_EOF;
      end
      ST_WAIT_EOF: begin
        if (rx_valid) begin
          take             = 1'b1;
          flags_d[ERR_GAP] = 1'b1;
          state_d          = ST_RECV;
        end else if (sil >= cfg_t35) begin
          if (!addr_ok && close_err == '0) begin
            len_d   = '0;
            crc_d   = CRC16_INIT;
            flags_d = '0;
            state_d = ST_IDLE;
          end else begin
            done_d  = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (frm_ack) begin
          len_d   = '0;
          crc_d   = CRC16_INIT;
          flags_d = '0;
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // IDLE relies on len/crc/flags already being in their cleared state.
    if (take) begin
      crc_d             = crc_nxt;
      flags_d[ERR_UART] = flags_d[ERR_UART] | rx_err;
      if (len < LEN_W'(MAX_LEN)) begin
        wr_en   = 1'b1;
        wr_addr = len[AW-1:0];
        len_d   = len + LEN_W'(1);
      end else begin
        flags_d[ERR_OVF] = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= ST_INIT;
      len      <= '0;
      crc      <= CRC16_INIT;
      flags    <= '0;
      addr0    <= '0;
      frm_done <= 1'b0;
      frm_len  <= '0;
      frm_ok   <= 1'b0;
      frm_err  <= '0;
    end else begin
      state    <= state_d;
      len      <= len_d;
      crc      <= crc_d;
      flags    <= flags_d;
      addr0    <= addr0_d;
      frm_done <= done_d;
      if (done_d) begin
        frm_len <= len;
        frm_err <= close_err;
        frm_ok  <= (close_err == '0);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (wr_en) mem[wr_addr] <= rx_data;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) frm_rd_data <= '0;
    else          frm_rd_data <= mem[frm_rd_addr];
  end

  assign busy = (state != ST_IDLE) && (state != ST_INIT);

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// Directed bench for the RTU receive framer: good/bad frames, gap, address
// filter, overflow, short frame, ack/byte collision and reset behaviour.
module tb_modbus_rtu_rx_framer;

  localparam int MAX_LEN = 8;
  localparam int TICK_W  = 20;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [TICK_W-1:0] cfg_t15 = TICK_W'(16);
  logic [TICK_W-1:0] cfg_t35 = TICK_W'(40);
  logic [7:0]        cfg_slave_addr = 8'h01;
  logic              cfg_addr_chk = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_err = 1'b0;
  logic              frm_done;
  logic [LEN_W-1:0]  frm_len;
  logic              frm_ok;
  logic [4:0]        frm_err;
  logic [LEN_W-2:0]  frm_rd_addr = '0;
  logic [7:0]        frm_rd_data;
  logic              frm_ack = 1'b0;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] frame [16];
  int flen = 0;

  modbus_rtu_rx_framer #(.MAX_LEN(MAX_LEN), .TICK_W(TICK_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cfg_t15(cfg_t15), .cfg_t35(cfg_t35),
    .cfg_slave_addr(cfg_slave_addr), .cfg_addr_chk(cfg_addr_chk),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .frm_done(frm_done), .frm_len(frm_len), .frm_ok(frm_ok), .frm_err(frm_err),
    .frm_rd_addr(frm_rd_addr), .frm_rd_data(frm_rd_data),
    .frm_ack(frm_ack), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) if (frm_done) done_cnt++;

  // ---- stimulus helpers (all called at a negedge, return at a negedge) ----
  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_valid = 1'b1; rx_data = b; rx_err = e;
    @(negedge PCLK);
    rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic send_frame(input int gap_after, input int err_idx);
    for (int i = 0; i < flen; i++) begin
      send_byte(frame[i], i == err_idx);
      if (i < flen - 1) idle(i == gap_after ? 19 : 9);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge PCLK);
      cyc++;
      if (frm_done) break;
    end
  endtask

  task automatic do_ack();
    frm_ack = 1'b1;
    @(negedge PCLK);
    frm_ack = 1'b0;
  endtask

  task automatic load_good();
    frame[0] = 8'h01; frame[1] = 8'h03; frame[2] = 8'h00; frame[3] = 8'h00;
    frame[4] = 8'h00; frame[5] = 8'h0A; frame[6] = 8'hC5; frame[7] = 8'hCD;
    flen = 8;
  endtask

  // ---- tests ----
  task automatic test_reset();
    idle(2);
    checks++; if (frm_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frm_done); end
    checks++; if (frm_len !== '0) begin errors++; $display("FAIL reset_len got %0d want 0", frm_len); end
    checks++; if (frm_ok !== 1'b0 || frm_err !== 5'b0) begin errors++; $display("FAIL reset_status got ok=%b err=%b want 0/00000", frm_ok, frm_err); end
    checks++; if (frm_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", frm_rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    PRESETn = 1'b1;
  endtask

  task automatic test_good_frame();
    int cyc;
    idle(50);
    load_good();
    send_frame(-1, -1);
    wait_done(cyc);
    checks++; if (cyc != 41) begin errors++; $display("FAIL good_latency got %0d want 41", cyc); end
    checks++; if (frm_len !== LEN_W'(8)) begin errors++; $display("FAIL good_len got %0d want 8", frm_len); end
    checks++; if (frm_ok !== 1'b1 || frm_err !== 5'b00000) begin errors++; $display("FAIL good_status got ok=%b err=%b want 1/00000", frm_ok, frm_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_hold got %b want 1", busy); end
    @(negedge PCLK);
    checks++; if (frm_done !== 1'b0) begin errors++; $display("FAIL good_pulse_width got %b want 0", frm_done); end
    for (int i = 0; i < 8; i++) begin
      frm_rd_addr = (LEN_W-1)'(i);
      @(negedge PCLK);
      checks++; if (frm_rd_data !== frame[i]) begin errors++; $display("FAIL good_readback[%0d] got %h want %h", i, frm_rd_data, frame[i]); end
    end
    checks++; if (frm_len !== LEN_W'(8) || frm_ok !== 1'b1) begin errors++; $display("FAIL good_hold_stable got len=%0d ok=%b want 8/1", frm_len, frm_ok); end
    do_ack();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_ack_busy got %b want 0", busy); end
  endtask

  task automatic test_bad_crc();
    int cyc;
    idle(50);
    load_good();
    frame[7] = 8'hCC;
    send_frame(-1, -1);
    wait_done(cyc);
    checks++; if (cyc != 41) begin errors++; $display("FAIL badcrc_latency got %0d want 41", cyc); end
    checks++; if (frm_ok !== 1'b0 || frm_err !== 5'b00010) begin errors++; $display("FAIL badcrc_status got ok=%b err=%b want 0/00010", frm_ok, frm_err); end
    do_ack();
  endtask

  task automatic test_gap();
    int cyc;
    idle(50);
    load_good();
    send_frame(2, -1);
    wait_done(cyc);
    checks++; if (cyc != 41) begin errors++; $display("FAIL gap_latency got %0d want 41", cyc); end
    checks++; if (frm_len !== LEN_W'(8)) begin errors++; $display("FAIL gap_len got %0d want 8", frm_len); end
    checks++; if (frm_ok !== 1'b0 || frm_err !== 5'b00100) begin errors++; $display("FAIL gap_status got ok=%b err=%b want 0/00100", frm_ok, frm_err); end
    do_ack();
  endtask

  task automatic test_uart_err();
    int cyc;
    idle(50);
    load_good();
    send_frame(-1, 1);
    wait_done(cyc);
    checks++; if (frm_ok !== 1'b0 || frm_err !== 5'b10000) begin errors++; $display("FAIL uart_status got ok=%b err=%b want 0/10000", frm_ok, frm_err); end
    do_ack();
  endtask

  task automatic test_addr_filter();
    int cyc, d0;
    idle(50);
    cfg_slave_addr = 8'h02;
    load_good();
    d0 = done_cnt;
    send_frame(-1, -1);
    idle(80);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL addr_discard_done got %0d pulses want 0", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL addr_discard_busy got %b want 0", busy); end
    // broadcast frame, CRC bytes precomputed for 00 03 00 00 00 0A
    load_good();
    frame[0] = 8'h00; frame[6] = 8'hC4; frame[7] = 8'h1C;
    send_frame(-1, -1);
    wait_done(cyc);
    checks++; if (cyc != 41) begin errors++; $display("FAIL bcast_latency got %0d want 41", cyc); end
    checks++; if (frm_ok !== 1'b1 || frm_err !== 5'b00000 || frm_len !== LEN_W'(8)) begin errors++; $display("FAIL bcast_status got ok=%b err=%b len=%0d want 1/00000/8", frm_ok, frm_err, frm_len); end
    frm_rd_addr = '0;
    @(negedge PCLK);
    checks++; if (frm_rd_data !== 8'h00) begin errors++; $display("FAIL bcast_byte0 got %h want 00", frm_rd_data); end
    do_ack();
    cfg_slave_addr = 8'h01;
  endtask

  task automatic test_overflow();
    int cyc;
    idle(50);
    load_good();
    frame[8] = 8'h11; frame[9] = 8'h22; flen = 10;
    send_frame(-1, -1);
    wait_done(cyc);
    checks++; if (frm_len !== LEN_W'(8)) begin errors++; $display("FAIL ovf_len got %0d want 8", frm_len); end
    checks++; if (frm_ok !== 1'b0 || frm_err !== 5'b01010) begin errors++; $display("FAIL ovf_status got ok=%b err=%b want 0/01010", frm_ok, frm_err); end
    frm_rd_addr = (LEN_W-1)'(7);
    @(negedge PCLK);
    checks++; if (frm_rd_data !== 8'hCD) begin errors++; $display("FAIL ovf_last_byte got %h want cd", frm_rd_data); end
    do_ack();
  endtask

  task automatic test_short();
    int cyc;
    idle(50);
    frame[0] = 8'h01; frame[1] = 8'h02; frame[2] = 8'h03; flen = 3;
    send_frame(-1, -1);
    wait_done(cyc);
    checks++; if (cyc != 41) begin errors++; $display("FAIL short_latency got %0d want 41", cyc); end
    checks++; if (frm_len !== LEN_W'(3)) begin errors++; $display("FAIL short_len got %0d want 3", frm_len); end
    checks++; if (frm_err[0] !== 1'b1 || frm_ok !== 1'b0) begin errors++; $display("FAIL short_status got ok=%b err=%b want 0/xxxx1", frm_ok, frm_err); end
    do_ack();
  endtask

  task automatic test_ack_with_byte();
    int cyc;
    idle(50);
    load_good();
    send_frame(-1, -1);
    wait_done(cyc);
    frm_ack = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge PCLK);
    frm_ack = 1'b0; rx_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ackbyte_busy got %b want 0", busy); end
    idle(10);
    send_byte(8'h01, 1'b0);
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ackbyte_init_ignore got %b want 0", busy); end
    idle(50);
    load_good();
    send_frame(-1, -1);
    wait_done(cyc);
    checks++; if (cyc != 41 || frm_ok !== 1'b1 || frm_len !== LEN_W'(8)) begin errors++; $display("FAIL ackbyte_next_frame got cyc=%0d ok=%b len=%0d want 41/1/8", cyc, frm_ok, frm_len); end
    do_ack();
  endtask

  task automatic test_reset_midframe();
    int cyc, d0;
    idle(50);
    load_good();
    for (int i = 0; i < 4; i++) begin
      send_byte(frame[i], 1'b0);
      idle(9);
    end
    PRESETn = 1'b0;
    @(negedge PCLK);
    checks++; if (frm_len !== '0 || frm_ok !== 1'b0 || frm_err !== 5'b0 || frm_done !== 1'b0) begin errors++; $display("FAIL midreset_outputs got len=%0d ok=%b err=%b done=%b want 0", frm_len, frm_ok, frm_err, frm_done); end
    checks++; if (busy !== 1'b0 || frm_rd_data !== 8'h00) begin errors++; $display("FAIL midreset_state got busy=%b rd=%h want 0/00", busy, frm_rd_data); end
    PRESETn = 1'b1;
    d0 = done_cnt;
    idle(10);
    send_byte(8'h01, 1'b0);
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startup_ignore_busy got %b want 0", busy); end
    idle(100);
    checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL startup_no_done got %0d pulses busy=%b want 0/0", done_cnt - d0, busy); end
    send_frame(-1, -1);
    wait_done(cyc);
    checks++; if (cyc != 41 || frm_ok !== 1'b1) begin errors++; $display("FAIL postreset_frame got cyc=%0d ok=%b want 41/1", cyc, frm_ok); end
    do_ack();
  endtask

  initial begin
    @(negedge PCLK);
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_gap();
    test_uart_err();
    test_addr_filter();
    test_overflow();
    test_short();
    test_ack_with_byte();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modbus_rtu_rx_framer.md
Name: modbus_rtu_rx_framer

Overview:
- Sits between the UART receiver and the Modbus request decoder inside top_modbus_converter.
- Consumes the received byte stream and finds RTU frame boundaries from inter-character silence (t1.5 and t3.5).
- Buffers each frame, checks CRC-16/MODBUS and slave address, then presents the frame to the decoder through a random-read port and a done/ack handshake.

Parameters:
- MAX_LEN, 256: frame buffer depth in bytes (the RTU maximum ADU size).
- TICK_W, 20: width of the silence counter and of the timeout config fields.
- LEN_W, $clog2(MAX_LEN+1): width of frm_len.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- cfg_t15  in  TICK_W  t1.5 threshold in PCLK cycles.
- cfg_t35  in  TICK_W  t3.5 threshold in PCLK cycles; must be greater than cfg_t15.
- cfg_slave_addr  in  8  own station address.
- cfg_addr_chk  in  1  when 1, discard frames not addressed to this station.
- rx_valid  in  1  one-cycle strobe: a byte was received.
- rx_data  in  8  received byte, qualified by rx_valid.
- rx_err  in  1  parity/framing error on the byte; qualified by rx_valid.
- frm_done  out  1  one-cycle pulse: a frame is ready.
- frm_len  out  LEN_W  number of stored bytes, including the 2 CRC bytes.
- frm_ok  out  1  frame has no error.
- frm_err  out  5  {uart, ovf, gap, crc, short}.
- frm_rd_addr  in  LEN_W-1  buffer read index.
- frm_rd_data  out  8  buffer byte; registered, 1-cycle read latency.
- frm_ack  in  1  decoder has finished with the frame; releases the buffer.
- busy  out  1  state is not IDLE or INIT.

Behaviour:
- Silence counter `sil`
  - Cleared to 0 on any rx_valid.
  - Otherwise increments each cycle and saturates at all-ones.
  - Runs in every state.
- Reset
  - State INIT, sil=0, len=0, crc=16'hFFFF, error flags 0.
  - All outputs 0; frm_rd_data=0.
  - Reset asserted mid-frame discards the partial frame; no frm_done is produced.
- INIT
  - Any byte is ignored.
  - When sil reaches cfg_t35, go to IDLE.
- IDLE
  - rx_valid: store the byte at index 0, len=1, crc=update(FFFF, byte), err_uart=rx_err, go to RECV.
- RECV
  - rx_valid: store the byte at index len when len<MAX_LEN; otherwise set err_ovf and do not store. len saturates at MAX_LEN.
  - Each byte updates crc and ORs rx_err into err_uart.
  - When sil reaches cfg_t15, go to WAIT_EOF.
- WAIT_EOF
  - rx_valid: set err_gap, then process the byte exactly as in RECV and return to RECV.
  - When sil reaches cfg_t35, close the frame:
    - err_short = (len<4).
    - err_crc = (crc!=0): residue check over all bytes, including the received CRC.
    - Address test: addr_ok = !cfg_addr_chk OR buf[0]==cfg_slave_addr OR buf[0]==8'h00 (broadcast).
    - If addr_ok is false and no error flag is set: discard silently, clear len/crc/flags, go to IDLE.
    - Otherwise: pulse frm_done for 1 cycle (the cycle after closing), latch frm_len, frm_ok and frm_err, go to HOLD.
- HOLD
  - frm_len, frm_ok and frm_err are held stable.
  - Incoming bytes are dropped.
  - frm_ack: clear len/crc/flags and go to INIT, so a full t3.5 silence is required again; sil is not reset by ack.
  - frm_ack outside HOLD is ignored.
- CRC
  - Reflected polynomial 16'hA001, one byte per cycle (8 unrolled shift/xor steps).
- Simultaneous events
  - rx_valid in the same cycle as a sil threshold match: the byte wins, sil is cleared, and no transition is taken.
  - rx_valid and frm_ack in the same HOLD cycle: the byte is dropped and the ack is taken.

Decomposition:
- Package modbus_pkg holds:
  - the state enum (INIT, IDLE, RECV, WAIT_EOF, HOLD);
  - the frm_err bit indices;
  - CRC16_INIT = 16'hFFFF and CRC16_POLY = 16'hA001;
  - the MODBUS_BCAST_ADDR = 8'h00 constant.
- Sub-module modbus_crc16_byte: combinational next-CRC function, also reused by the TX framer.
- The buffer is an inferred 1R1W RAM.

Test Plan:
- Good frame
  - Stimulus: cfg_t15=16, cfg_t35=40, addr 01; wait 40 idle cycles, then send 01 03 00 00 00 0A C5 CD at 10-cycle spacing.
  - Required response: frm_done 40 cycles after the last byte, frm_len=8, frm_ok=1, frm_err=0; read-back of all 8 bytes matches.
- Bad CRC
  - Stimulus: same frame with the last byte CC.
  - Required response: frm_done, frm_ok=0, frm_err=00010 (crc).
- Gap violation
  - Stimulus: insert a 20-cycle gap between bytes 3 and 4.
  - Required response: frm_err gap bit set, frm_len=8.
- Address filtering
  - Stimulus: cfg_slave_addr=02 with the good frame.
  - Required response: no frm_done, state returns to IDLE.
  - Stimulus: a frame starting with 00 whose CRC is correct for 00 03 00 00 00 0A.
  - Required response: accepted with frm_ok=1.
- Overflow and short frame
  - Stimulus: MAX_LEN=8, send 10 bytes.
  - Required response: frm_len=8, ovf set.
  - Stimulus: a 3-byte frame.
  - Required response: short set.
- Reset and startup
  - Stimulus: assert PRESETn low after 4 bytes.
  - Required response: outputs 0, state INIT.
  - Stimulus: a byte arriving before 40 idle cycles after reset.
  - Required response: byte ignored, frm_done never pulses for it.
